// File: rtl/swevt_pkg.sv
// swevt_pkg: shared event types, direction codes and width helper for the switch event tracker
package swevt_pkg;
  localparam logic EVT_UP = 1'b1;
  localparam logic EVT_DOWN = 1'b0;
  localparam int MAX_IDW = 4;
  localparam logic [MAX_IDW-1:0] NONE_ID = '1;
  typedef struct packed {
    logic [MAX_IDW-1:0] id;
    logic               dir;
  } evt_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/swevt_fifo.sv
// swevt_fifo: first-word-fall-through FIFO; push ignored when full, pop ignored when empty
// Ports: CLK, RESET (async, active-high), i_push/i_data write side, i_pop read side,
//        o_data head word, o_full, o_empty.
module swevt_fifo
  import swevt_pkg::*;
#(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp, r_rp;
  logic         w_push, w_pop;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = r_wp == r_rp;
  // extra pointer bit distinguishes full from empty when the index bits match
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_data  = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_mem <= '{default: '0};
    end else begin
      if (w_push) begin
        r_mem[r_wp[AW-1:0]] <= i_data;
        r_wp                <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
endmodule

// File: rtl/switch_event_tracker.sv
// switch_event_tracker: turns net switch level changes into an ordered up/down event stream and an up-order stack
// Ports: CLK, RESET (async, active-high), SW raw levels (1 = up);
//        EVT_VALID/EVT_READY/EVT_ID/EVT_DIR event handshake (DIR 1 = up);
//        ACTIVE_VALID/ACTIVE_ID most recently raised switch still up; UP_COUNT stack depth.
// Build option: define SWEVT_SYNC_EN to add a two-flop synchroniser on SW.
module switch_event_tracker
  import swevt_pkg::*;
#(
  parameter int N_SW       = 10,
  parameter int FIFO_DEPTH = 4,
  localparam int IDW       = clog2(N_SW),
  localparam int CNTW      = clog2(N_SW + 1)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N_SW-1:0] SW,
  output logic            EVT_VALID,
  input  logic            EVT_READY,
  output logic [IDW-1:0]  EVT_ID,
  output logic            EVT_DIR,
  output logic            ACTIVE_VALID,
  output logic [IDW-1:0]  ACTIVE_ID,
  output logic [CNTW-1:0] UP_COUNT
);
  logic [N_SW-1:0] w_sw_s;
`ifdef SWEVT_SYNC_EN
  localparam int PRIME_EDGES = 3;
  logic [N_SW-1:0] r_sync1, r_sync2;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= SW;
      r_sync2 <= r_sync1;
    end
  assign w_sw_s = r_sync2;
`else
  localparam int PRIME_EDGES = 1;
  assign w_sw_s = SW;
`endif
  logic [1:0]      r_prime_cnt;
  logic            w_primed, w_svc, w_dir, w_full, w_empty, w_hit;
  logic [N_SW-1:0] r_sw_q, r_pend, w_chg, w_sel;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  r_stack [N_SW];
  logic [IDW-1:0]  w_stack_n [N_SW];
  logic [CNTW-1:0] r_count, w_count_n, w_pos;
  evt_t            w_push_evt, w_head;
  // pend stays frozen until the history register holds a settled post-reset sample
  assign w_primed = r_prime_cnt == 2'(PRIME_EDGES);
  assign w_chg    = w_sw_s ^ r_sw_q;
  always_comb begin
    w_idx = '0;
    for (int k = N_SW - 1; k >= 0; k--) if (r_pend[k]) w_idx = IDW'(k);
  end
  assign w_svc      = w_primed && (|r_pend) && !w_full;
  assign w_sel      = w_svc ? (N_SW'(1) << w_idx) : '0;
  assign w_dir      = r_sw_q[w_idx];
  assign w_push_evt = '{id: MAX_IDW'(w_idx), dir: w_dir};
  // a down event for a switch that was already up at reset finds no slot and leaves the stack alone
  always_comb begin
    w_hit = 1'b0;
    w_pos = '0;
    for (int k = 0; k < N_SW; k++)
      if (CNTW'(k) < r_count && r_stack[k] == w_idx) begin
        w_hit = 1'b1;
        w_pos = CNTW'(k);
      end
    w_stack_n = r_stack;
    w_count_n = r_count;
    if (w_svc && w_dir == EVT_UP) begin
      for (int k = 0; k < N_SW; k++) if (CNTW'(k) == r_count) w_stack_n[k] = w_idx;
      w_count_n = r_count + 1'b1;
    end else if (w_svc && w_hit) begin
      for (int k = 0; k < N_SW - 1; k++) if (CNTW'(k) >= w_pos) w_stack_n[k] = r_stack[k+1];
      w_stack_n[N_SW-1] = '0;
      w_count_n         = r_count - 1'b1;
    end
  end
  always_comb begin
    ACTIVE_ID = NONE_ID[IDW-1:0];
    for (int k = 0; k < N_SW; k++) if (CNTW'(k + 1) == r_count) ACTIVE_ID = r_stack[k];
  end
  assign ACTIVE_VALID = r_count != '0;
  assign UP_COUNT     = r_count;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_prime_cnt <= '0;
      r_sw_q      <= '0;
      r_pend      <= '0;
      r_stack     <= '{default: '0};
      r_count     <= '0;
    end else begin
      r_sw_q  <= w_sw_s;
      r_stack <= w_stack_n;
      r_count <= w_count_n;
      if (!w_primed) r_prime_cnt <= r_prime_cnt + 1'b1;
      else r_pend <= r_pend ^ w_chg ^ w_sel;
    end
  swevt_fifo #(.W($bits(evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_push (w_svc),
    .i_data (w_push_evt),
    .i_pop  (EVT_READY),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  assign EVT_VALID = !w_empty;
  assign EVT_ID    = w_head.id[IDW-1:0];
  assign EVT_DIR   = w_head.dir;
endmodule

// File: tb/tb_switch_event_tracker.sv
// tb_switch_event_tracker: directed and random checks of switch_event_tracker against an event/stack model
module tb_switch_event_tracker;
  localparam int N = 10;
  localparam int D = 4;
  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         EVT_READY = 1'b0;
  logic [N-1:0] SW = '0;
  logic         EVT_VALID, EVT_DIR, ACTIVE_VALID;
  logic [3:0]   EVT_ID, ACTIVE_ID, UP_COUNT;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [N-1:0] m_lvl, m_rep;
  int           m_prime;
  logic [4:0]   m_q[$];
  int           m_stk[$];

  switch_event_tracker #(.N_SW(N), .FIFO_DEPTH(D)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .SW          (SW),
    .EVT_VALID   (EVT_VALID),
    .EVT_READY   (EVT_READY),
    .EVT_ID      (EVT_ID),
    .EVT_DIR     (EVT_DIR),
    .ACTIVE_VALID(ACTIVE_VALID),
    .ACTIVE_ID   (ACTIVE_ID),
    .UP_COUNT    (UP_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_lvl   = '0;
    m_rep   = '0;
    m_prime = 1;
    m_q.delete();
    m_stk.delete();
  endtask

  // Per switch: report whenever the last seen level differs from the last reported level,
  // lowest index first, while the queue has room (no room in a cycle that only frees a slot).
  task automatic model_edge();
    int  sel;
    int  f;
    bit  pop;
    if (RESET) return;
    if (m_prime > 0) begin
      m_lvl = SW;
      m_rep = SW;
      m_prime--;
      return;
    end
    pop = (m_q.size() != 0) && EVT_READY;
    sel = -1;
    for (int i = N - 1; i >= 0; i--) if (m_lvl[i] != m_rep[i]) sel = i;
    if (sel >= 0 && m_q.size() < D) begin
      m_q.push_back({4'(sel), m_lvl[sel]});
      m_rep[sel] = m_lvl[sel];
      if (m_lvl[sel]) m_stk.push_back(sel);
      else begin
        f = -1;
        foreach (m_stk[j]) if (m_stk[j] == sel) f = j;
        if (f >= 0) m_stk.delete(f);
      end
    end
    if (pop) void'(m_q.pop_front());
    m_lvl = SW;
  endtask

  task automatic check_all();
    chk("evt_valid", EVT_VALID, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("evt_id", EVT_ID, m_q[0][4:1]);
      chk("evt_dir", EVT_DIR, m_q[0][0]);
    end
    chk("active_valid", ACTIVE_VALID, m_stk.size() != 0);
    chk("active_id", ACTIVE_ID, m_stk.size() != 0 ? m_stk[$] : 15);
    chk("up_count", UP_COUNT, m_stk.size());
  endtask

  task automatic step(input logic [N-1:0] sw, input logic rdy);
    SW        = sw;
    EVT_READY = rdy;
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset(input logic [N-1:0] sw);
    SW    = sw;
    RESET = 1'b1;
    model_clear();
    #1;
    chk("rst_evt_valid", EVT_VALID, 0);
    chk("rst_evt_id", EVT_ID, 0);
    chk("rst_evt_dir", EVT_DIR, 0);
    chk("rst_active_valid", ACTIVE_VALID, 0);
    chk("rst_active_id", ACTIVE_ID, 15);
    chk("rst_up_count", UP_COUNT, 0);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RESET = 1'b0;
  endtask

  initial begin
    logic [N-1:0] s;
    int           b;
    // single raise, two-edge latency
    do_reset('0);
    step('0, 1);
    step(10'h008, 1);
    step(10'h008, 1);
    chk("t1_id", EVT_ID, 3);
    chk("t1_dir", EVT_DIR, 1);
    chk("t1_active", ACTIVE_ID, 3);
    chk("t1_count", UP_COUNT, 1);
    // raise 7, raise 5, drop 7
    repeat (3) step(10'h088, 1);
    repeat (3) step(10'h0a8, 1);
    repeat (3) step(10'h028, 1);
    chk("t2_active", ACTIVE_ID, 5);
    chk("t2_count", UP_COUNT, 2);
    // simultaneous raise of 2 and 8
    do_reset('0);
    step('0, 1);
    step(10'h104, 1);
    step(10'h104, 1);
    chk("t3_first", EVT_ID, 2);
    step(10'h104, 1);
    chk("t3_second", EVT_ID, 8);
    chk("t3_active", ACTIVE_ID, 8);
    // fill the FIFO, cancelled pulse on switch 1, then drain
    do_reset('0);
    step('0, 0);
    repeat (6) step(10'h07d, 0);
    chk("t4_full_valid", EVT_VALID, 1);
    chk("t4_full_head", EVT_ID, 0);
    chk("t4_full_count", UP_COUNT, 4);
    step(10'h07f, 0);
    step(10'h07d, 0);
    repeat (10) step(10'h07d, 1);
    chk("t4_drained", EVT_VALID, 0);
    chk("t4_count", UP_COUNT, 6);
    chk("t4_active", ACTIVE_ID, 6);
    // switch up through reset, then dropped
    do_reset(10'h010);
    repeat (4) step(10'h010, 1);
    chk("t6_no_evt", EVT_VALID, 0);
    step('0, 1);
    step('0, 1);
    chk("t6_id", EVT_ID, 4);
    chk("t6_dir", EVT_DIR, 0);
    chk("t6_active_valid", ACTIVE_VALID, 0);
    chk("t6_active_id", ACTIVE_ID, 15);
    repeat (5) step(10'h00e, 0);
    chk("t6_queued", EVT_VALID, 1);
    do_reset('0);
    // random traffic with occasional resets
    s = '0;
    step(s, 1);
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 199) == 0) begin
        s = N'($urandom);
        do_reset(s);
      end else begin
        repeat ($urandom_range(0, 2)) begin
          b    = $urandom_range(0, N - 1);
          s[b] = ~s[b];
        end
      end
      step(s, $urandom_range(0, 3) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
